// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the debug slow-clock / clock-enable generator.
// Optional cycle counter is enabled by defining CLK_DIV_CTRL_CYCLE_CNT_EN.
package clk_div_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IDLE_LOW = 2'd1,
    STEP_HI  = 2'd2,
    STEP_LO  = 2'd3
  } clk_div_state_e;

  localparam int          CLK_DIV_CNT_W    = 32;
  localparam int unsigned CLK_DIV_DEF_DIV  = 2500000;
  localparam int unsigned CLK_DIV_FAST_DIV = 0;

endpackage

// File: rtl/clk_div_ctrl_edge.sv
// Two-flop synchroniser with a rising-edge pulse; reusable for button-style inputs.
// rise is high for one clk cycle after a 0->1 transition has passed through the synchroniser.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= din;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider with free-run, halt and single-step modes.
// Define CLK_DIV_CTRL_CYCLE_CNT_EN to add the cycle_cnt output (count of tick pulses).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = CLK_DIV_CNT_W,
  parameter int unsigned DEF_DIV  = CLK_DIV_DEF_DIV,
  parameter int unsigned FAST_DIV = CLK_DIV_FAST_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_freq,
  input  logic             halt,
  input  logic             step_mode,
  input  logic             step,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_data,
  output logic             div_ack,
  output logic             slow_clk,
  output logic             tick,
  output logic             busy,
  output clk_div_state_e   state_dbg
`ifdef CLK_DIV_CTRL_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEF_DIV_W  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] FAST_DIV_W = CNT_W'(FAST_DIV);
  localparam logic [CNT_W-1:0] ONE_W      = CNT_W'(1);

  clk_div_state_e   state_q, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [CNT_W-1:0] d_act_q, d_act_n;
  logic [CNT_W-1:0] div_reg_q, div_reg_n;
  logic [CNT_W-1:0] shadow_q, shadow_n;
  logic             shadow_vld_q, shadow_vld_n;
  logic             slow_q, slow_n;
  logic             tick_q, tick_n;
  logic             busy_q, busy_n;
  logic             ack_q, ack_n;

  logic             step_rise;
  logic             copy;
  logic [CNT_W-1:0] d_new;
  logic [CNT_W-1:0] d_cmp;
  logic             terminal;

  edge_detect_rise u_step_edge (
    .clk   (clk),
    .reset (reset),
    .din   (step),
    .rise  (step_rise)
  );

  // Divisor handshake: div_wr is a single-cycle strobe with no ready; the value sits in
  // the shadow until a safe point (terminal count, IDLE_LOW or halt), and div_ack pulses
  // for one cycle when the copy into div_reg has happened. Later writes overwrite the shadow.
  assign copy  = shadow_vld_q && (halt || (state_q == IDLE_LOW) || (count_q == d_act_q));
  assign d_new = set_freq ? FAST_DIV_W : (copy ? shadow_q : div_reg_q);

  // In IDLE_LOW the counter is at zero, so the freshest divisor can be used immediately.
  assign d_cmp    = (state_q == IDLE_LOW) ? d_new : d_act_q;
  assign terminal = (count_q == d_cmp);

  always_comb begin
    state_n      = state_q;
    count_n      = count_q;
    d_act_n      = d_act_q;
    slow_n       = slow_q;
    tick_n       = 1'b0;
    busy_n       = busy_q;
    div_reg_n    = div_reg_q;
    shadow_n     = shadow_q;
    shadow_vld_n = shadow_vld_q;
    ack_n        = 1'b0;

    if (halt) begin
      // Holding RUN restarts the low half from count 0 once halt drops.
      state_n = step_mode ? IDLE_LOW : RUN;
      count_n = '0;
      slow_n  = 1'b0;
      busy_n  = 1'b0;
      d_act_n = d_new;
    end else begin
      unique case (state_q)
        IDLE_LOW: begin
          d_act_n = d_new;
          if (!step_mode) begin
            state_n = RUN;
            if (terminal) begin
              count_n = '0;
              slow_n  = 1'b1;
              tick_n  = 1'b1;
            end else begin
              count_n = count_q + ONE_W;
            end
          end else if (step_rise) begin
            state_n = STEP_HI;
            count_n = '0;
            slow_n  = 1'b1;
            tick_n  = 1'b1;
            busy_n  = 1'b1;
          end
        end

        RUN: begin
          if (terminal) begin
            count_n = '0;
            slow_n  = ~slow_q;
            tick_n  = ~slow_q;
            d_act_n = d_new;
            // Entering step mode finishes the high half and parks low.
            if (step_mode && slow_q) begin
              state_n = IDLE_LOW;
            end
          end else begin
            count_n = count_q + ONE_W;
          end
        end

        STEP_HI: begin
          if (terminal) begin
            state_n = STEP_LO;
            count_n = '0;
            slow_n  = 1'b0;
            d_act_n = d_new;
          end else begin
            count_n = count_q + ONE_W;
          end
        end

        STEP_LO: begin
          if (terminal) begin
            state_n = IDLE_LOW;
            count_n = '0;
            busy_n  = 1'b0;
            d_act_n = d_new;
          end else begin
            count_n = count_q + ONE_W;
          end
        end

        default: begin
          state_n = IDLE_LOW;
          count_n = '0;
          slow_n  = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end

    if (copy) begin
      div_reg_n    = shadow_q;
      shadow_vld_n = 1'b0;
      ack_n        = 1'b1;
    end
    // A write coinciding with a copy stays pending for the next safe point.
    if (div_wr) begin
      shadow_n     = div_data;
      shadow_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE_LOW;
      count_q      <= '0;
      d_act_q      <= DEF_DIV_W;
      slow_q       <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      div_reg_q    <= DEF_DIV_W;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      count_q      <= count_n;
      d_act_q      <= d_act_n;
      slow_q       <= slow_n;
      tick_q       <= tick_n;
      busy_q       <= busy_n;
      div_reg_q    <= div_reg_n;
      shadow_q     <= shadow_n;
      shadow_vld_q <= shadow_vld_n;
      ack_q        <= ack_n;
    end
  end

`ifdef CLK_DIV_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;

  // Cleared only by reset; halt leaves the running total alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
    end else if (tick_n) begin
      cycle_cnt_q <= cycle_cnt_q + ONE_W;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

  assign slow_clk  = slow_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign div_ack   = ack_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with DEF_DIV=3, FAST_DIV=0, CNT_W=8.
// Outputs are sampled on the falling edge; inputs change right after that sample.
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             set_freq;
  logic             halt;
  logic             step_mode;
  logic             step;
  logic             div_wr;
  logic [CNT_W-1:0] div_data;
  logic             div_ack;
  logic             slow_clk;
  logic             tick;
  logic             busy;
  clk_div_state_e   state_dbg;
`ifdef CLK_DIV_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  clk_div_ctrl #(
    .CNT_W    (CNT_W),
    .DEF_DIV  (3),
    .FAST_DIV (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_freq  (set_freq),
    .halt      (halt),
    .step_mode (step_mode),
    .step      (step),
    .div_wr    (div_wr),
    .div_data  (div_data),
    .div_ack   (div_ack),
    .slow_clk  (slow_clk),
    .tick      (tick),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef CLK_DIV_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic t, input logic b);
    chk({tag, "_slow"}, 32'(slow_clk), 32'(s));
    chk({tag, "_tick"}, 32'(tick), 32'(t));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    logic [1:0] e;
    reset = 1'b0; set_freq = 1'b0; halt = 1'b0; step_mode = 1'b0;
    step = 1'b0; div_wr = 1'b0; div_data = '0;

    // Reset state
    repeat (3) nxt();
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_ack", 32'(div_ack), 0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE_LOW));

    // Free run, D=3: period 8, first tick 4 edges after release
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) exp_q.push_back({((k / 4) % 2) == 1, (k % 8) == 4});
    for (int k = 1; k <= 16; k++) begin
      nxt();
      e = exp_q.pop_front();
      chk($sformatf("free_k%0d_slow", k), 32'(slow_clk), 32'(e[1]));
      chk($sformatf("free_k%0d_tick", k), 32'(tick), 32'(e[0]));
    end

    // Fast rate: applied at the terminal count of edge 20, then toggles every cycle
    set_freq = 1'b1;
    for (int k = 17; k <= 28; k++) begin
      nxt();
      chk($sformatf("fast_k%0d_slow", k), 32'(slow_clk), 32'((k >= 20) && (k % 2 == 0)));
      chk($sformatf("fast_k%0d_tick", k), 32'(tick), 32'((k >= 20) && (k % 2 == 0)));
    end

    // Halt in high half, back to programmed divisor
    set_freq = 1'b0; halt = 1'b1;
    nxt();
    chk_out("halt0", 1'b0, 1'b0, 1'b0);
    chk("halt0_state", 32'(state_dbg), 32'(RUN));
    halt = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      nxt();
      chk($sformatf("rel_r%0d_tick", r), 32'(tick), 32'(r == 4));
      chk($sformatf("rel_r%0d_slow", r), 32'(slow_clk), 32'(r == 4));
    end

    // Divisor write mid high half: old half completes, then D=1
    nxt();                                      // R5
    div_wr = 1'b1; div_data = 8'd1;
    nxt(); div_wr = 1'b0;                       // R6
    chk("dw_r6_slow", 32'(slow_clk), 1); chk("dw_r6_ack", 32'(div_ack), 0);
    nxt();                                      // R7
    chk("dw_r7_slow", 32'(slow_clk), 1); chk("dw_r7_ack", 32'(div_ack), 0);
    nxt();                                      // R8
    chk("dw_r8_slow", 32'(slow_clk), 0); chk("dw_r8_ack", 32'(div_ack), 1);
    nxt();                                      // R9
    chk("dw_r9_slow", 32'(slow_clk), 0); chk("dw_r9_ack", 32'(div_ack), 0);
    nxt(); chk_out("dw_r10", 1'b1, 1'b1, 1'b0);
    nxt(); chk_out("dw_r11", 1'b1, 1'b0, 1'b0);
    nxt(); chk_out("dw_r12", 1'b0, 1'b0, 1'b0);
    nxt(); chk_out("dw_r13", 1'b0, 1'b0, 1'b0);
    nxt(); chk_out("dw_r14", 1'b1, 1'b1, 1'b0);

    // Two writes before the terminal count: a single ack, last value wins
    nxt();                                      // R15
    div_wr = 1'b1; div_data = 8'd5;
    nxt(); div_data = 8'd1;                     // R16
    chk("dw2_r16_ack", 32'(div_ack), 0); chk("dw2_r16_slow", 32'(slow_clk), 0);
    nxt(); div_wr = 1'b0;                       // R17
    chk("dw2_r17_ack", 32'(div_ack), 0);
    nxt();                                      // R18
    chk("dw2_r18_ack", 32'(div_ack), 1); chk_out("dw2_r18", 1'b1, 1'b1, 1'b0);
    for (int r = 19; r <= 22; r++) begin
      nxt();
      chk($sformatf("dw2_r%0d_ack", r), 32'(div_ack), 0);
      chk($sformatf("dw2_r%0d_tick", r), 32'(tick), 32'(r == 22));
    end

    // Enter step mode: finish the high half, park in IDLE_LOW
    step_mode = 1'b1;
    nxt();                                      // R23
    chk("sm_r23_slow", 32'(slow_clk), 1); chk("sm_r23_state", 32'(state_dbg), 32'(RUN));
    nxt();                                      // R24
    chk("sm_r24_slow", 32'(slow_clk), 0); chk("sm_r24_state", 32'(state_dbg), 32'(IDLE_LOW));

    // Divisor write while idle: ack one cycle after the write
    div_wr = 1'b1; div_data = 8'd2;
    nxt(); div_wr = 1'b0;                       // R25
    chk("idw_r25_ack", 32'(div_ack), 0);
    nxt(); chk("idw_r26_ack", 32'(div_ack), 1); // R26
    nxt(); chk("idw_r27_ack", 32'(div_ack), 0); // R27

    // Single step with D=2; a second step edge while busy is ignored
    step = 1'b1;
    nxt(); chk_out("st_r28", 1'b0, 1'b0, 1'b0);
    nxt(); chk_out("st_r29", 1'b1, 1'b1, 1'b1);
    chk("st_r29_state", 32'(state_dbg), 32'(STEP_HI));
    nxt(); chk_out("st_r30", 1'b1, 1'b0, 1'b1);
    step = 1'b0;
    nxt(); chk_out("st_r31", 1'b1, 1'b0, 1'b1);
    step = 1'b1;
    nxt(); chk_out("st_r32", 1'b0, 1'b0, 1'b1);
    chk("st_r32_state", 32'(state_dbg), 32'(STEP_LO));
    nxt(); chk_out("st_r33", 1'b0, 1'b0, 1'b1);
    nxt(); chk_out("st_r34", 1'b0, 1'b0, 1'b1);
    nxt(); chk_out("st_r35", 1'b0, 1'b0, 1'b0);
    chk("st_r35_state", 32'(state_dbg), 32'(IDLE_LOW));
    for (int r = 36; r <= 39; r++) begin
      nxt();
      chk_out($sformatf("st_r%0d", r), 1'b0, 1'b0, 1'b0);
    end

    // Back to free run with D=2, then halt mid high half
    step = 1'b0; step_mode = 1'b0;
    nxt(); chk("fr_r40_state", 32'(state_dbg), 32'(RUN)); chk("fr_r40_slow", 32'(slow_clk), 0);
    nxt();
    nxt(); chk_out("fr_r42", 1'b1, 1'b1, 1'b0);
    nxt(); chk_out("fr_r43", 1'b1, 1'b0, 1'b0);
    halt = 1'b1;
    for (int r = 44; r <= 46; r++) begin
      nxt();
      chk_out($sformatf("hl_r%0d", r), 1'b0, 1'b0, 1'b0);
    end
    halt = 1'b0;
    nxt(); chk_out("hl_r47", 1'b0, 1'b0, 1'b0);
    nxt(); chk_out("hl_r48", 1'b0, 1'b0, 1'b0);
    nxt(); chk_out("hl_r49", 1'b1, 1'b1, 1'b0);

    // Halt with step_mode: idle immediately, shadow copied while halted
    halt = 1'b1; step_mode = 1'b1; div_wr = 1'b1; div_data = 8'd7;
    nxt(); div_wr = 1'b0;                       // R50
    chk("hs_r50_state", 32'(state_dbg), 32'(IDLE_LOW)); chk("hs_r50_ack", 32'(div_ack), 0);
    chk_out("hs_r50", 1'b0, 1'b0, 1'b0);
    nxt(); chk("hs_r51_ack", 32'(div_ack), 1);  // R51
    halt = 1'b0; step = 1'b1;
    nxt(); chk("hs_r52_ack", 32'(div_ack), 0);  // R52
    nxt(); chk_out("hs_r53", 1'b1, 1'b1, 1'b1); // R53
    nxt(); chk_out("hs_r54", 1'b1, 1'b0, 1'b1); // R54

    // Reset during STEP_HI
    reset = 1'b0;
    nxt();
    chk_out("rs2", 1'b0, 1'b0, 1'b0);
    chk("rs2_ack", 32'(div_ack), 0);
    chk("rs2_state", 32'(state_dbg), 32'(IDLE_LOW));
`ifdef CLK_DIV_CTRL_CYCLE_CNT_EN
    chk("rs2_cycle_cnt", 32'(cycle_cnt), 0);
`endif
    // div_reg back to DEF_DIV=3: first tick 4 edges after release
    reset = 1'b1; step = 1'b0; step_mode = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      nxt();
      chk($sformatf("rs2_f%0d_tick", f), 32'(tick), 32'(f == 4));
      chk($sformatf("rs2_f%0d_slow", f), 32'(slow_clk), 32'(f == 4));
    end
`ifdef CLK_DIV_CTRL_CYCLE_CNT_EN
    chk("cc_f4", 32'(cycle_cnt), 1);
    repeat (32) nxt();
    chk("cc_f36", 32'(cycle_cnt), 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Parametrised slow-clock / clock-enable generator for the processor's board-level debug clocking.
- Divides the system clock by a divisor that can be changed at run time.
- Supports free-run, halt and single-step modes.
- Produces a 50%-duty `slow_clk` plus a one-cycle `tick` enable aligned to each slow-clock rising edge, so downstream logic can stay on `clk`.

Parameters:
- CNT_W, 32, width of counter and divisor registers.
- DEF_DIV, 2500000, divisor loaded at reset (half-period = DEF_DIV+1 clk cycles).
- FAST_DIV, 0, divisor used while `set_freq`=1 (fastest rate: `slow_clk` = clk/2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- set_freq  in  1  1 = use FAST_DIV; 0 = use programmed divisor.
- halt  in  1  level; freezes output low.
- step_mode  in  1  level; 1 = single-step mode, 0 = free-run.
- step  in  1  single-step request; edge-detected internally.
- div_wr  in  1  one-cycle write strobe for new divisor.
- div_data  in  CNT_W  new divisor value.
- div_ack  out  1  one-cycle pulse when the written divisor takes effect.
- slow_clk  out  1  divided clock.
- tick  out  1  one-cycle pulse in the cycle `slow_clk` goes 0->1.
- busy  out  1  a single-step period is in progress.

Behaviour:
- Reset (reset=0 at posedge):
  - count=0, slow_clk=0, tick=0, div_ack=0, busy=0.
  - div_reg=DEF_DIV, shadow invalid, state=IDLE_LOW.
  - Reset overrides all other inputs, including mid-step.
- Effective divisor D = set_freq ? FAST_DIV : div_reg.
  - `set_freq` is sampled every cycle.
  - A change takes effect at the next terminal count.
- Counter:
  - Increments each active cycle.
  - Terminal when count==D: count<=0 and slow_clk toggles.
  - Each half-period is D+1 clk cycles; full period is 2(D+1).
  - Comparison is unsigned, CNT_W bits.
  - If a lowered D leaves count>D, the comparison is ==, so the counter wraps at 2^CNT_W. This is why D is only applied at a terminal count, which prevents this case.
- `tick`:
  - Registered, asserted exactly in the cycle `slow_clk` becomes 1.
  - Never asserted during halt or reset.
- States:
  - RUN: step_mode=0, halt=0. Free-running toggle.
  - IDLE_LOW: step_mode=1, not busy. slow_clk=0, count=0.
    - A rising edge of `step` -> STEP_HI: slow_clk<=1, tick=1, busy=1.
  - STEP_HI: count to D, then -> STEP_LO with slow_clk<=0.
  - STEP_LO: count to D, then -> IDLE_LOW with busy<=0.
  - `step` edges while busy are ignored (not queued).
  - RUN -> IDLE_LOW when step_mode rises: the current period completes (until the terminal count ending the high half) and lands on low, then idles.
  - IDLE_LOW -> RUN when step_mode falls with busy=0.
  - step_mode falling while busy: the step completes first.
- `halt` (priority below reset, above everything else):
  - slow_clk<=0, count<=0, tick=0, busy<=0.
  - State goes to IDLE_LOW if step_mode=1, otherwise it is held so that RUN restarts from count 0 with slow_clk low once halt drops.
- Divisor load:
  - `div_wr` latches `div_data` into the shadow and sets shadow valid.
  - Shadow is copied to div_reg at the next terminal count, or in the next cycle if in IDLE_LOW or halted.
  - div_ack=1 for exactly the copy cycle.
  - A second div_wr before the copy overwrites the shadow; one ack is issued, for the last value.
  - div_wr in the same cycle as a copy: the copy uses the old shadow and the new value stays pending.

Optional Feature:
- Macro: CLK_DIV_CTRL_CYCLE_CNT_EN.
- With the macro defined:
  - Adds output `cycle_cnt` [CNT_W-1:0], which counts `tick` pulses.
  - Wraps at 2^CNT_W.
  - Reset to 0 by reset=0 only; halt does not clear it.
- Without the macro: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package clk_div_pkg contains:
  - State enum (RUN, IDLE_LOW, STEP_HI, STEP_LO).
  - Localparams for DEF_DIV and FAST_DIV defaults.
- One sub-module, `edge_detect_rise`:
  - Registered `step` synchroniser plus rising-edge pulse.
  - Reused for any future button inputs.

Test Plan:
- Reset released, DEF_DIV=3, set_freq=0, free-run -> slow_clk period 8 clk; tick every 8 cycles, first tick 4 cycles after reset release.
- set_freq=1 with FAST_DIV=0 -> slow_clk toggles every cycle; tick every 2 cycles.
- With D=3, div_wr with div_data=1 mid-half-period -> old half completes (4 cycles), div_ack pulses at that terminal count, then 2-cycle halves; two writes (5 then 1) -> single ack, D=1.
- step_mode=1, D=2, one step pulse -> slow_clk high 3 cycles then low 3 cycles, busy high 6 cycles, one tick; a second step during busy -> no extra period.
- halt asserted mid-high-half -> slow_clk=0 next cycle, no ticks; release -> first tick D+1 cycles later.
- reset=0 during STEP_HI -> all outputs 0 next cycle, div_reg=DEF_DIV; with CLK_DIV_CTRL_CYCLE_CNT_EN, cycle_cnt=0 after reset and equals 5 after 5 ticks.
